// File: rtl/event_status_ctrl.sv
// event_status_ctrl: shares the event-status DPSRAM between OR-update
// producers on port A and read/clear-on-read consumers on port B.
module event_status_ctrl #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clr_all_req,
  output logic              init_done,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_mask,
  input  logic              qry_valid,
  output logic              qry_ready,
  input  logic [ADDR_W-1:0] qry_addr,
  input  logic [DATA_W-1:0] qry_clr_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_a_addr,
  output logic [DATA_W-1:0] ram_a_din,
  output logic              ram_a_wen,
  input  logic [DATA_W-1:0] ram_a_dout,
  output logic [ADDR_W-1:0] ram_b_addr,
  output logic [DATA_W-1:0] ram_b_din,
  output logic              ram_b_wen,
  input  logic [DATA_W-1:0] ram_b_dout,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {CLR, RUN, DRAIN} top_e;
  typedef enum logic [1:0] {P_IDLE, P_RD, P_WB} port_e;

  top_e              state_q;
  port_e             a_st_q, b_st_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] a_mask_q, b_mask_q;
  logic              a_wen_q, b_wen_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [15:0]       stall_q, stall_d;

  logic run, sweep_end;
  logic a_busy, b_busy, a_can, b_can;
  logic haz_a, haz_b, upd_acc, qry_acc, stall;

  assign run       = (state_q == RUN);
  assign sweep_end = ptr_q[ADDR_W-1];
  assign a_busy    = (a_st_q != P_IDLE);
  assign b_busy    = (b_st_q != P_IDLE);
  assign a_can     = run && (a_st_q != P_RD);
  assign b_can     = run && (b_st_q != P_RD);

  // Equal-address tie in the same cycle goes to the producer.
  assign haz_a   = b_busy && (b_addr_q == upd_addr);
  assign upd_ready = a_can && !haz_a;
  assign upd_acc = upd_valid && upd_ready;
  assign haz_b   = (a_busy && (a_addr_q == qry_addr))
                || (upd_acc && (upd_addr == qry_addr));
  assign qry_ready = b_can && !haz_b;
  assign qry_acc = qry_valid && qry_ready;

  assign stall = (upd_valid && a_can && haz_a)
              || (qry_valid && b_can && haz_b);
  assign stall_d = (stall && (stall_q != 16'hFFFF))
                 ? stall_q + 16'd1 : stall_q;

  assign init_done  = run;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign stall_cnt  = stall_q;
  assign ram_a_addr = a_addr_q;
  assign ram_b_addr = b_addr_q;
  assign ram_a_wen  = a_wen_q;
  assign ram_b_wen  = b_wen_q;

  assign ram_a_din = (a_st_q == P_WB) ? (ram_a_dout | a_mask_q)
                   : (a_wen_q ? CLR_VALUE : '0);
  assign ram_b_din = (b_st_q == P_WB) ? (ram_b_dout & ~b_mask_q)
                   : (b_wen_q ? CLR_VALUE : '0);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= CLR;
      ptr_q       <= '0;
      a_st_q      <= P_IDLE;
      b_st_q      <= P_IDLE;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      a_mask_q    <= '0;
      b_mask_q    <= '0;
      a_wen_q     <= 1'b0;
      b_wen_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      stall_q     <= '0;
    end else begin
      stall_q     <= stall_d;
      rsp_valid_q <= (b_st_q == P_WB);
      if (b_st_q == P_WB) rsp_data_q <= ram_b_dout;
      unique case (state_q)
        CLR: begin
          a_st_q  <= P_IDLE;
          b_st_q  <= P_IDLE;
          a_wen_q <= !sweep_end;
          b_wen_q <= !sweep_end;
          if (sweep_end) begin
            state_q <= RUN;
          end else begin
            a_addr_q <= {ptr_q[ADDR_W-2:0], 1'b0};
            b_addr_q <= {ptr_q[ADDR_W-2:0], 1'b1};
            ptr_q    <= ptr_q + ADDR_W'(1);
          end
        end
        default: begin
          if (upd_acc) begin
            a_st_q   <= P_RD;
            a_addr_q <= upd_addr;
            a_mask_q <= upd_mask;
            a_wen_q  <= 1'b0;
          end else if (a_st_q == P_RD) begin
            a_st_q  <= P_WB;
            a_wen_q <= 1'b1;
          end else begin
            a_st_q  <= P_IDLE;
            a_wen_q <= 1'b0;
          end
          if (qry_acc) begin
            b_st_q   <= P_RD;
            b_addr_q <= qry_addr;
            b_mask_q <= qry_clr_mask;
            b_wen_q  <= 1'b0;
          end else if (b_st_q == P_RD) begin
            b_st_q  <= P_WB;
            b_wen_q <= |b_mask_q;
          end else begin
            b_st_q  <= P_IDLE;
            b_wen_q <= 1'b0;
          end
          if (run && clr_all_req) begin
            state_q <= DRAIN;
          end else if ((state_q == DRAIN) && !a_busy && !b_busy) begin
            state_q <= CLR;
            ptr_q   <= '0;
          end
        end
      endcase
    end
  end

endmodule
